// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge channel between the memory stage and the data memory.
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (output dm_req, dm_we, dm_addr, dm_wdata, input dm_ack, dm_rdata);
  modport slave  (input dm_req, dm_we, dm_addr, dm_wdata, output dm_ack, dm_rdata);
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: redirects, HI/LO, req/ack data access with upstream stall, MEM/WB register.
// Optional access timeout with sticky dm_err is enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        multu_enM,
  input  logic        jr_selM,
  input  logic        branchM,
  input  logic        dm2regM,
  input  logic        jumpM,
  input  logic        we_dmM,
  input  logic        jal_selM,
  input  logic        we_regM,
  input  logic [1:0]  super_selM,
  input  logic        zeroM,
  input  logic [31:0] pc_plus_4M,
  input  logic [31:0] btaM,
  input  logic [31:0] alu_paM,
  input  logic [31:0] jtaM,
  input  logic [31:0] wd_dmM,
  input  logic [31:0] shiftyM,
  input  logic [63:0] alu_outM,
  input  logic [4:0]  rf_waM,
  mem_stage_if.master dm,
  output logic        stall_mem,
  output logic        redirect,
  output logic [31:0] pc_target,
  output logic [31:0] HI_q,
  output logic [31:0] LO_q,
  output logic        dm_err,
  output logic        we_regW,
  output logic [4:0]  rf_waW,
  output logic [31:0] rf_wdW
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        access_s;
  logic        timeout_s;
  logic        adv_s;
  logic [31:0] load_data_s;
  logic [31:0] wb_data_s;
  logic [4:0]  wb_addr_s;

  assign access_s = dm2regM | we_dmM;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_r;

  // The request cycle spent in IDLE counts as the first wait, so abort on the last ACCESS slot.
  assign timeout_s = (state_r == ACCESS) && (wait_cnt_r == CNT_W'(TIMEOUT - 1)) && !dm.dm_ack;

  // Wait counter: zero in IDLE, counts ACCESS cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= '0;
    end else if (state_r == ACCESS) begin
      wait_cnt_r <= wait_cnt_r + 1'b1;
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_err <= 1'b0;
    end else if (timeout_s) begin
      dm_err <= 1'b1;
    end else begin
      dm_err <= dm_err;
    end
  end
`else
  logic unused_timeout_s;
  assign timeout_s        = 1'b0;
  assign dm_err           = 1'b0;
  assign unused_timeout_s = (TIMEOUT == 32'sd0);
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (access_s && !dm.dm_ack) state_next_s = ACCESS;
        else                        state_next_s = IDLE;
      end
      ACCESS: begin
        if (dm.dm_ack || timeout_s) state_next_s = IDLE;
        else                        state_next_s = ACCESS;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: memory request, stall and redirect.
  always_comb begin
    dm.dm_req   = access_s;
    dm.dm_we    = we_dmM;
    dm.dm_addr  = alu_outM[31:0];
    dm.dm_wdata = wd_dmM;
    stall_mem   = access_s & ~dm.dm_ack & ~timeout_s;
    adv_s       = ~stall_mem;
    redirect    = adv_s & (jr_selM | jumpM | (branchM & zeroM));
    if (jr_selM) begin
      pc_target = alu_paM;
    end else if (jumpM) begin
      pc_target = jtaM;
    end else begin
      pc_target = btaM;
    end
  end

  // Write-back source selection; HI/LO reads see the pre-update registers.
  always_comb begin
    load_data_s = timeout_s ? 32'd0 : dm.dm_rdata;
    wb_addr_s   = rf_waM;
    wb_data_s   = alu_outM[31:0];
    if (jal_selM) begin
      wb_addr_s = 5'd31;
      wb_data_s = pc_plus_4M;
    end else begin
      case (super_selM)
        2'b01:   wb_data_s = HI_q;
        2'b10:   wb_data_s = LO_q;
        2'b11:   wb_data_s = shiftyM;
        default: wb_data_s = dm2regM ? load_data_s : alu_outM[31:0];
      endcase
    end
  end

  // HI/LO pair loaded by multu when the stage advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HI_q <= 32'd0;
      LO_q <= 32'd0;
    end else if (adv_s && multu_enM) begin
      HI_q <= alu_outM[63:32];
      LO_q <= alu_outM[31:0];
    end else begin
      HI_q <= HI_q;
      LO_q <= LO_q;
    end
  end

  // MEM/WB register; a stall inserts a bubble and holds address/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_regW <= 1'b0;
      rf_waW  <= 5'd0;
      rf_wdW  <= 32'd0;
    end else if (adv_s) begin
      we_regW <= we_regM;
      rf_waW  <= wb_addr_s;
      rf_wdW  <= wb_data_s;
    end else begin
      we_regW <= 1'b0;
      rf_waW  <= rf_waW;
      rf_wdW  <= rf_wdW;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage against a behavioural model of the stage.
module tb_mem_stage;
  logic        clk;
  logic        rst_n;
  logic        multu_enM, jr_selM, branchM, dm2regM, jumpM, we_dmM, jal_selM, we_regM;
  logic [1:0]  super_selM;
  logic        zeroM;
  logic [31:0] pc_plus_4M, btaM, alu_paM, jtaM, wd_dmM, shiftyM;
  logic [63:0] alu_outM;
  logic [4:0]  rf_waM;
  logic        stall_mem, redirect, dm_err, we_regW;
  logic [31:0] pc_target, HI_q, LO_q, rf_wdW;
  logic [4:0]  rf_waW;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_hi, m_lo, m_wd;
  logic [4:0]  m_wa;

  mem_stage_if dmif ();

  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .multu_enM(multu_enM), .jr_selM(jr_selM), .branchM(branchM), .dm2regM(dm2regM),
    .jumpM(jumpM), .we_dmM(we_dmM), .jal_selM(jal_selM), .we_regM(we_regM),
    .super_selM(super_selM), .zeroM(zeroM), .pc_plus_4M(pc_plus_4M), .btaM(btaM),
    .alu_paM(alu_paM), .jtaM(jtaM), .wd_dmM(wd_dmM), .shiftyM(shiftyM),
    .alu_outM(alu_outM), .rf_waM(rf_waM), .dm(dmif),
    .stall_mem(stall_mem), .redirect(redirect), .pc_target(pc_target),
    .HI_q(HI_q), .LO_q(LO_q), .dm_err(dm_err), .we_regW(we_regW),
    .rf_waW(rf_waW), .rf_wdW(rf_wdW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    multu_enM = 1'b0; jr_selM = 1'b0; branchM = 1'b0; dm2regM = 1'b0;
    jumpM = 1'b0; we_dmM = 1'b0; jal_selM = 1'b0; we_regM = 1'b0;
    super_selM = 2'b00; zeroM = 1'b0;
    pc_plus_4M = 32'd0; btaM = 32'd0; alu_paM = 32'd0; jtaM = 32'd0;
    wd_dmM = 32'd0; shiftyM = 32'd0; alu_outM = 64'd0; rf_waM = 5'd0;
    dmif.dm_ack = 1'b0; dmif.dm_rdata = 32'd0;
  endtask

  task automatic model_reset();
    m_hi = 32'd0; m_lo = 32'd0; m_wd = 32'd0; m_wa = 5'd0;
  endtask

  // Runs the currently driven instruction; memory acks after wait_n wait cycles.
  // Entered and left at posedge+1.
  task automatic do_instr(input int wait_n);
    logic        acc, stalled, exp_redir;
    logic [31:0] exp_tgt, exp_wd;
    logic [4:0]  exp_wa;
    int          last;
    acc  = dm2regM | we_dmM;
    last = acc ? wait_n : 0;
    exp_tgt = jr_selM ? alu_paM : (jumpM ? jtaM : btaM);
    exp_wa  = jal_selM ? 5'd31 : rf_waM;
    if (jal_selM)                exp_wd = pc_plus_4M;
    else if (super_selM == 2'b01) exp_wd = m_hi;
    else if (super_selM == 2'b10) exp_wd = m_lo;
    else if (super_selM == 2'b11) exp_wd = shiftyM;
    else if (dm2regM)            exp_wd = dmif.dm_rdata;
    else                         exp_wd = alu_outM[31:0];
    for (int c = 0; c <= last; c++) begin
      dmif.dm_ack = acc && (c == wait_n);
      stalled = acc && (c < wait_n);
      exp_redir = !stalled && (jr_selM || jumpM || (branchM && zeroM));
      #3;
      checks++;
      if (stall_mem !== stalled) begin
        errors++; $display("FAIL stall_mem cyc %0d: got %b want %b", c, stall_mem, stalled);
      end
      checks++;
      if (dmif.dm_req !== acc) begin
        errors++; $display("FAIL dm_req: got %b want %b", dmif.dm_req, acc);
      end
      if (acc) begin
        checks++;
        if ({dmif.dm_we, dmif.dm_addr, dmif.dm_wdata} !== {we_dmM, alu_outM[31:0], wd_dmM}) begin
          errors++; $display("FAIL dm_bus: got we=%b a=%h d=%h want we=%b a=%h d=%h",
            dmif.dm_we, dmif.dm_addr, dmif.dm_wdata, we_dmM, alu_outM[31:0], wd_dmM);
        end
      end
      checks++;
      if (redirect !== exp_redir) begin
        errors++; $display("FAIL redirect: got %b want %b", redirect, exp_redir);
      end
      if (exp_redir) begin
        checks++;
        if (pc_target !== exp_tgt) begin
          errors++; $display("FAIL pc_target: got %h want %h", pc_target, exp_tgt);
        end
      end
      @(posedge clk); #1;
      if (stalled) begin
        checks++;
        if ({we_regW, rf_waW, rf_wdW} !== {1'b0, m_wa, m_wd}) begin
          errors++; $display("FAIL bubble: got we=%b wa=%0d wd=%h want we=0 wa=%0d wd=%h",
            we_regW, rf_waW, rf_wdW, m_wa, m_wd);
        end
      end else begin
        m_wa = exp_wa; m_wd = exp_wd;
        if (multu_enM) begin
          m_hi = alu_outM[63:32]; m_lo = alu_outM[31:0];
        end
        checks++;
        if ({we_regW, rf_waW, rf_wdW} !== {we_regM, m_wa, m_wd}) begin
          errors++; $display("FAIL writeback: got we=%b wa=%0d wd=%h want we=%b wa=%0d wd=%h",
            we_regW, rf_waW, rf_wdW, we_regM, m_wa, m_wd);
        end
        checks++;
        if ({HI_q, LO_q} !== {m_hi, m_lo}) begin
          errors++; $display("FAIL hilo: got %h_%h want %h_%h", HI_q, LO_q, m_hi, m_lo);
        end
      end
      checks++;
      if (dm_err !== 1'b0) begin
        errors++; $display("FAIL dm_err: got %b want 0", dm_err);
      end
    end
    dmif.dm_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    dm2regM = 1'b1;
    #2;
    checks++;
    if ({HI_q, LO_q, dm_err, we_regW, rf_waW, rf_wdW} !== 103'd0) begin
      errors++; $display("FAIL reset_regs: got %h %h %b %b %0d %h want all 0",
        HI_q, LO_q, dm_err, we_regW, rf_waW, rf_wdW);
    end
    checks++;
    if ({dmif.dm_req, stall_mem} !== 2'b11) begin
      errors++; $display("FAIL reset_comb: got req=%b stall=%b want 1 1", dmif.dm_req, stall_mem);
    end
    dm2regM = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_zero_wait();
    clear_inputs();
    dm2regM = 1'b1; alu_outM = 64'h100; dmif.dm_rdata = 32'hCAFEF00D;
    we_regM = 1'b1; rf_waM = 5'd5;
    do_instr(0);
    checks++;
    if ({we_regW, rf_wdW} !== {1'b1, 32'hCAFEF00D}) begin
      errors++; $display("FAIL load0: got we=%b wd=%h want 1 cafef00d", we_regW, rf_wdW);
    end
  endtask

  task automatic test_store_wait3();
    clear_inputs();
    we_dmM = 1'b1; alu_outM = 64'h200; wd_dmM = 32'hDEADBEEF;
    do_instr(3);
  endtask

  task automatic test_multu();
    clear_inputs();
    multu_enM = 1'b1; alu_outM = 64'h00000001_80000000;
    do_instr(0);
    checks++;
    if ({HI_q, LO_q} !== 64'h00000001_80000000) begin
      errors++; $display("FAIL multu: got %h_%h want 00000001_80000000", HI_q, LO_q);
    end
    clear_inputs();
    super_selM = 2'b10; we_regM = 1'b1; rf_waM = 5'd9;
    do_instr(0);
    checks++;
    if (rf_wdW !== 32'h80000000) begin
      errors++; $display("FAIL mflo: got %h want 80000000", rf_wdW);
    end
    // multu and mfhi together: the old HI is written back
    clear_inputs();
    multu_enM = 1'b1; alu_outM = 64'h12345678_9ABCDEF0; super_selM = 2'b01; we_regM = 1'b1;
    do_instr(0);
    checks++;
    if ({rf_wdW, HI_q} !== {32'h00000001, 32'h12345678}) begin
      errors++; $display("FAIL mfhi_pre: got wd=%h hi=%h want 00000001 12345678", rf_wdW, HI_q);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    branchM = 1'b1; zeroM = 1'b1; btaM = 32'h40;
    do_instr(0);
    alu_paM = 32'h80; jr_selM = 1'b1;
    do_instr(0);
    jr_selM = 1'b0; dm2regM = 1'b1; dmif.dm_rdata = 32'h55AA55AA;
    do_instr(2);
  endtask

  task automatic test_jal();
    clear_inputs();
    jal_selM = 1'b1; pc_plus_4M = 32'h24; we_regM = 1'b1; rf_waM = 5'd3;
    do_instr(0);
    checks++;
    if ({rf_waW, rf_wdW} !== {5'd31, 32'h24}) begin
      errors++; $display("FAIL jal: got wa=%0d wd=%h want 31 24", rf_waW, rf_wdW);
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 150; n++) begin
      clear_inputs();
      multu_enM = ($urandom_range(0, 3) == 0);
      jr_selM   = ($urandom_range(0, 7) == 0);
      jumpM     = ($urandom_range(0, 7) == 0);
      branchM   = ($urandom_range(0, 3) == 0);
      zeroM     = 1'($urandom);
      jal_selM  = ($urandom_range(0, 7) == 0);
      we_regM   = 1'($urandom);
      super_selM = 2'($urandom);
      r = $urandom_range(0, 3);
      dm2regM = (r == 0);
      we_dmM  = (r == 1);
      pc_plus_4M = $urandom; btaM = $urandom; alu_paM = $urandom; jtaM = $urandom;
      wd_dmM = $urandom; shiftyM = $urandom; alu_outM = {$urandom, $urandom};
      rf_waM = 5'($urandom); dmif.dm_rdata = $urandom;
      do_instr($urandom_range(0, 4));
    end
  endtask

  task automatic test_reset_mid_access();
    clear_inputs();
    dm2regM = 1'b1; we_regM = 1'b1; rf_waM = 5'd12; dmif.dm_rdata = 32'h0BADF00D;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0; model_reset(); #1;
    checks++;
    if ({dm_err, we_regW, rf_waW, rf_wdW, HI_q} !== 71'd0) begin
      errors++; $display("FAIL rst_mid: got err=%b we=%b wa=%0d wd=%h hi=%h want 0",
        dm_err, we_regW, rf_waW, rf_wdW, HI_q);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if ({dmif.dm_req, stall_mem} !== 2'b11) begin
      errors++; $display("FAIL rst_rereq: got req=%b stall=%b want 1 1", dmif.dm_req, stall_mem);
    end
    dmif.dm_ack = 1'b1; #1;
    checks++;
    if (stall_mem !== 1'b0) begin
      errors++; $display("FAIL rst_ack: got stall=%b want 0", stall_mem);
    end
    @(posedge clk); #1;
    m_wa = 5'd12; m_wd = 32'h0BADF00D;
    checks++;
    if ({we_regW, rf_waW, rf_wdW} !== {1'b1, m_wa, m_wd}) begin
      errors++; $display("FAIL rst_wb: got we=%b wa=%0d wd=%h want 1 12 0badf00d",
        we_regW, rf_waW, rf_wdW);
    end
    clear_inputs();
  endtask

`ifdef MEM_STAGE_TIMEOUT_EN
  task automatic test_timeout();
    clear_inputs();
    dm2regM = 1'b1; we_regM = 1'b1; rf_waM = 5'd7; dmif.dm_rdata = 32'h12345678;
    for (int c = 0; c <= 16; c++) begin
      #3;
      checks++;
      if (stall_mem !== (c < 16)) begin
        errors++; $display("FAIL to_stall cyc %0d: got %b want %b", c, stall_mem, (c < 16));
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({dm_err, we_regW, rf_waW, rf_wdW} !== {1'b1, 1'b1, 5'd7, 32'd0}) begin
      errors++; $display("FAIL to_wb: got err=%b we=%b wa=%0d wd=%h want 1 1 7 0",
        dm_err, we_regW, rf_waW, rf_wdW);
    end
    clear_inputs();
    @(posedge clk); #1;
    checks++;
    if (dm_err !== 1'b1) begin
      errors++; $display("FAIL to_sticky: got %b want 1", dm_err);
    end
    dm2regM = 1'b1;
    repeat (5) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    checks++;
    if ({dm_err, stall_mem} !== 2'b01) begin
      errors++; $display("FAIL to_rst: got err=%b stall=%b want 0 1", dm_err, stall_mem);
    end
    @(negedge clk); rst_n = 1'b1;
    // the full wait budget restarts after reset
    for (int c = 0; c <= 16; c++) begin
      if (c == 0) #1; else #3;
      checks++;
      if (stall_mem !== (c < 16)) begin
        errors++; $display("FAIL to_rst_stall cyc %0d: got %b want %b", c, stall_mem, (c < 16));
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    model_reset();
    m_wd = 32'd0;
  endtask
`else
  task automatic test_no_timeout();
    clear_inputs();
    dm2regM = 1'b1; dmif.dm_rdata = 32'h0F0F0F0F; we_regM = 1'b1; rf_waM = 5'd2;
    do_instr(40);
  endtask
`endif

  initial begin
    test_reset();
    test_load_zero_wait();
    test_store_wait3();
    test_multu();
    test_branch();
    test_jal();
    test_random();
    test_reset_mid_access();
`ifdef MEM_STAGE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage MIPS pipeline, directly downstream of the EXE/MEM pipeline register. It resolves branch, jump and jr redirects, and owns the HI/LO register pair written by `multu`. It runs data-memory accesses over a req/ack handshake and stalls the upstream pipeline while an access is outstanding. It selects the write-back value and registers it into the MEM/WB boundary.

## Interface
- `TIMEOUT`, 16: wait cycles before an unacknowledged access is aborted. Used only with `MEM_STAGE_TIMEOUT_EN`.
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `multu_enM`, `jr_selM`, `branchM`, `dm2regM`, `jumpM`, `we_dmM`, `jal_selM`, `we_regM`  in  1 each  M-stage control.
- `super_selM`  in  2  write-back source: 00 ALU/mem, 01 HI, 10 LO, 11 shifter.
- `zeroM`  in  1  ALU zero flag.
- `pc_plus_4M`, `btaM`, `alu_paM`, `jtaM`, `wd_dmM`, `shiftyM`  in  32 each.
- `alu_outM`  in  64  ALU result; [31:0] is the address/result, [63:32] is the `multu` high word.
- `rf_waM`  in  5  destination register.
- `dm_req`  out  1  memory request.
- `dm_we`  out  1  memory write enable.
- `dm_addr`  out  32  memory address.
- `dm_wdata`  out  32  memory write data.
- `dm_ack`  in  1  memory acknowledge.
- `dm_rdata`  in  32  memory read data.
- `stall_mem`  out  1  hold request to all upstream stage registers.
- `redirect`  out  1  take `pc_target` and flush younger instructions.
- `pc_target`  out  32  redirect address.
- `HI_q`, `LO_q`  out  32 each  current HI/LO, exported to decode.
- `dm_err`  out  1  sticky timeout flag.
- `we_regW`  out  1  MEM/WB register-write enable.
- `rf_waW`  out  5  MEM/WB destination register.
- `rf_wdW`  out  32  MEM/WB write data.

## Operation
- `access = dm2regM | we_dmM`.
- `dm_req = access & state==ACCESS` or `access & state==IDLE`. The request is held high until ack.
- `dm_we = we_dmM`, `dm_addr = alu_outM[31:0]`, `dm_wdata = wd_dmM`. These are only meaningful while `dm_req` is high.
- `stall_mem = dm_req & ~dm_ack`.
- `adv = ~stall_mem`.
- FSM states are IDLE and ACCESS:
  - IDLE→ACCESS when `dm_req & ~dm_ack`.
  - ACCESS→IDLE on `dm_ack`, or on timeout.
  - An ack in the same cycle as the request completes from IDLE without a stall.
- Redirect: `redirect = adv & (jr_selM | jumpM | (branchM & zeroM))`. It is never asserted while stalled.
- Redirect target priority: `jr_selM` → `alu_paM`; else `jumpM` → `jtaM`; else `btaM`.
- HI/LO: on `adv & multu_enM`, load `HI ← alu_outM[63:32]` and `LO ← alu_outM[31:0]`.
  - `HI_q` and `LO_q` are the registered values.
  - An instruction selecting HI/LO reads the pre-update value.
- Write-back data selection:
  - `jal_selM` → `pc_plus_4M`, with `rf_waW ← 31`.
  - Else `super_selM` 01 → `HI_q`.
  - 10 → `LO_q`.
  - 11 → `shiftyM`.
  - 00 → `dm_rdata` if `dm2regM`, else `alu_outM[31:0]`.
- MEM/WB update on `adv`: `we_regW ← we_regM`, `rf_waW`, `rf_wdW ← selected`.
- MEM/WB update while stalled: `we_regW ← 0` (bubble), with `rf_waW` and `rf_wdW` holding their values.

## Timing
- Reset (async, `rst_n`=0) clears all state. Every registered output becomes 0:
  - FSM is IDLE.
  - `HI_q`, `LO_q`, `dm_err`, `we_regW`, `rf_waW`, `rf_wdW` are 0.
  - Combinational outputs follow their inputs.
- A reset during ACCESS abandons the access. `dm_req` can reassert on the first cycle after release if `access` is still high.
- Write-back latency is 1 cycle after the advancing cycle.
- A zero-wait memory (ack in the request cycle) causes no stall.
- An ack after N wait cycles causes N stall cycles, followed by one advance.
- `dm_rdata` is sampled in the ack cycle.
- Upstream must hold all M inputs stable while `stall_mem`=1.

## Configuration
- `MEM_STAGE_TIMEOUT_EN` defined:
  - A wait counter clears in IDLE and increments each ACCESS cycle.
  - When the counter reaches `TIMEOUT` without an ack, the FSM returns to IDLE and `dm_err` ← 1. `dm_err` is sticky until reset.
  - The stage advances that cycle: a load writes 0, and a store is dropped.
- `MEM_STAGE_TIMEOUT_EN` undefined: no counter; the FSM waits for ack indefinitely; `dm_err` is tied to 0.

## Test plan
- Load, ack in the same cycle: `dm2regM`=1, `alu_outM`=0x100, `dm_rdata`=0xCAFEF00D → no stall; next cycle `we_regW`=1 and `rf_wdW`=0xCAFEF00D.
- Store, ack after 3 cycles: `stall_mem`=1 for 3 cycles; `dm_req`, `dm_we`, `dm_addr` and `dm_wdata` are stable throughout; `we_regW`=0 bubbles during the stall.
- `multu`: `alu_outM`=0x00000001_80000000 with `multu_enM`=1 → next cycle `HI_q`=1 and `LO_q`=0x80000000. A following instruction with `super_selM`=10 writes 0x80000000.
- Branch: `branchM`=1, `zeroM`=1, `btaM`=0x40 → `redirect`=1, `pc_target`=0x40. With `jr_selM`=1 and `alu_paM`=0x80 also set, `pc_target`=0x80. With a simultaneous pending access, `redirect` stays 0 until the ack.
- `jal`: `jal_selM`=1, `pc_plus_4M`=0x24 → `rf_waW`=31, `rf_wdW`=0x24.
- Timeout (macro on, `TIMEOUT`=16), ack held low:
  - Stall for exactly 16 cycles, then `dm_err`=1 and the load writes 0.
  - Asserting `rst_n`=0 mid-wait clears `dm_err` and the FSM immediately.
